// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversampling ratios and bit-centre
// positions, plus the 3-sample majority vote used for bit recovery.
package uart_pkg;

    localparam int OSR_13 = 13;
    localparam int OSR_16 = 16;
    localparam int CTR_13 = 6;
    localparam int CTR_16 = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-level output channel of the UART receiver: valid/ready handshake with
// the received byte and its error flags.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 framing_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, framing_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, framing_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Input conditioning for the receiver: rxd metastability synchroniser (idles high)
// and rising-edge detector turning the oversample square wave into a one-cycle tick.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic m_clk,
    input  logic reset,
    input  logic rxd,
    input  logic rx_clk,
    output logic rxd_s,
    output logic tick
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_clk_q;

    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '1;
            rx_clk_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rx_clk_q <= rx_clk;
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];
    // rx_clk is generated by the baud generator in this same clock domain
    assign tick  = rx_clk & ~rx_clk_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: oversampled start detection, 3-sample majority voting per
// bit, and a valid/ready byte output with framing and sticky overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            m_clk,
    input  logic            reset,
    input  logic            osm_sel,
    input  logic            rx_clk,
    input  logic            rxd,
    output logic            busy,
    uart_receiver_if.master rx
);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic rxd_s;
    logic tick;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .m_clk  (m_clk),
        .reset  (reset),
        .rxd    (rxd),
        .rx_clk (rx_clk),
        .rxd_s  (rxd_s),
        .tick   (tick)
    );

    rx_state_e            state_q,   state_d;
    logic [3:0]           os_cnt_q,  os_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [1:0]           samp_q,    samp_d;
    logic                 osr16_q,   osr16_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;

    logic       done;
    logic       done_ferr;
    logic       vote;
    logic       accept;
    logic [3:0] ctr;
    logic [3:0] ctr_m1;
    logic [3:0] ctr_p1;
    logic [3:0] n_last;

    always_comb begin
        ctr    = osr16_q ? 4'(CTR_16) : 4'(CTR_13);
        n_last = osr16_q ? 4'(OSR_16 - 1) : 4'(OSR_13 - 1);
        ctr_m1 = ctr - 4'd1;
        ctr_p1 = ctr + 4'd1;
        // third sample is the live line value on the C+1 tick
        vote   = maj3(samp_q[0], samp_q[1], rxd_s);
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        osr16_d   = osr16_q;
        done      = 1'b0;
        done_ferr = 1'b0;

        if (tick) begin
            if (state_q != ST_IDLE) begin
                os_cnt_d = os_cnt_q + 4'd1;
                if (os_cnt_q == ctr_m1) samp_d[0] = rxd_s;
                if (os_cnt_q == ctr)    samp_d[1] = rxd_s;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d  = ST_START;
                        os_cnt_d = 4'd0;
                        osr16_d  = osm_sel;
                    end
                end
                ST_START: begin
                    if (os_cnt_q == ctr_p1 && vote) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = 4'd0;
                    end else if (os_cnt_q == n_last) begin
                        state_d   = ST_DATA;
                        os_cnt_d  = 4'd0;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (os_cnt_q == ctr_p1) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (os_cnt_q == n_last) begin
                        os_cnt_d = 4'd0;
                        if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
                        else                       bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    // leave at the stop-bit centre so a back-to-back start edge is not missed
                    if (os_cnt_q == ctr_p1) begin
                        done      = 1'b1;
                        done_ferr = ~vote;
                        state_d   = ST_IDLE;
                        os_cnt_d  = 4'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign accept = valid_q & rx.rx_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (done && (!valid_q || accept)) begin
            data_d  = shift_q;
            ferr_d  = done_ferr;
            valid_d = 1'b1;
        end else if (done) begin
            ovr_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            os_cnt_q  <= 4'd0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            samp_q    <= 2'b11;
            osr16_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            osr16_q   <= osr16_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.framing_err = ferr_q;
    assign rx.overrun_err = ovr_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive path of the UART. Consumes the oversampling `rx_clk` produced by `baud_generator` as a sampled enable (not as a clock), recovers 8N1 frames from the asynchronous `rxd` line with 3-sample majority voting, and presents each byte on a valid/ready output with framing and overrun flags. Runs entirely in the `m_clk` domain, so it sits beside `baud_generator` and feeds the host-side register/FIFO logic.

## Interface
- `DATA_BITS`, 8, payload bits per frame, LSB first.
- `SYNC_STAGES`, 2, flops in the `rxd` synchroniser (≥2).
- `m_clk`  in  1  system clock (100 MHz); the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `osm_sel`  in  1  0 = 13× oversampling, 1 = 16× (same encoding as `baud_generator`).
- `rx_clk`  in  1  oversample square wave from `baud_generator`, sampled in `m_clk`.
- `rxd`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  DATA_BITS  received byte.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts byte when `rx_valid && rx_ready`.
- `framing_err`  out  1  stop bit of the byte on `rx_data` sampled low; qualified by `rx_valid`.
- `overrun_err`  out  1  sticky; a frame completed while `rx_valid` was high.
- `busy`  out  1  high from start-bit detection to stop-bit decision.

## Operation
- Tick: `rx_clk` registered into `rx_clk_q`; `tick = rx_clk & ~rx_clk_q` (one `m_clk` pulse per `rx_clk` rising edge = one oversample period).
- OSR N = 13 or 16; latched from `osm_sel` on start detection, held for the frame. Centre C = 6 (N=13) or 8 (N=16); vote samples at tick counts C-1, C, C+1; bit value = majority of 3.
- States: IDLE, START, DATA, STOP.
- IDLE: on tick with synced `rxd`=0 → START, `os_cnt`=0, `busy`=1.
- START: count ticks; at `os_cnt`=C+1 evaluate vote: 1 → false start, back to IDLE, `busy`=0; 0 → continue; at `os_cnt`=N-1 → DATA, `os_cnt`=0, `bit_cnt`=0.
- DATA: vote each bit; at `os_cnt`=C+1 shift voted bit into MSB of shift register (LSB-first reception); at `os_cnt`=N-1 increment `bit_cnt`; after bit DATA_BITS-1 → STOP.
- STOP: at `os_cnt`=C+1 decide: load `rx_data` from shift register, `framing_err` = ~vote, set `rx_valid`; → IDLE immediately (half-bit early to catch back-to-back start).
- Overrun: frame completes while `rx_valid`=1 and not being accepted that cycle → `rx_data`/`framing_err` keep old byte, new byte dropped, `overrun_err` set; cleared only by reset.
- Simultaneous accept and completion in the same cycle: new byte loads, `rx_valid` stays 1, no overrun.
- Counters: `os_cnt` 4 bits, `bit_cnt` 3 bits (clog2(DATA_BITS)); no wrap beyond N-1.
- `osm_sel` change mid-frame has no effect until next IDLE→START.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE, `rx_data`=0, `rx_valid`=0, `framing_err`=0, `overrun_err`=0, `busy`=0, `rx_clk_q`=0, sync chain all 1 (idle line).
- `rxd` latency to FSM: SYNC_STAGES `m_clk`.
- `tick` asserts one `m_clk` after `rx_clk` rises as seen by `m_clk`.
- `rx_valid` rises one `m_clk` after the STOP decision tick; falls the cycle after the `rx_valid && rx_ready` edge.
- Reset mid-frame: immediate return to IDLE, partial byte discarded, no `rx_valid`.

## Structure
- Package `uart_pkg`: state enum, `OSR_13`=13, `OSR_16`=16, `CTR_13`=6, `CTR_16`=8, shared with the future transmitter.
- One sub-module `uart_rx_sync`: `rxd` synchroniser plus `rx_clk` edge detector, outputs `rxd_s` and `tick`.

## Test plan
- 16× (`osm_sel`=1, divisor 163 clocks), send 0xA5 with stop=1 → `rx_data`=0xA5, `rx_valid`=1, `framing_err`=0, `busy` low after STOP centre.
- 13× (`osm_sel`=0, divisor 401), send 0x3C then 0xC3 back-to-back, `rx_ready`=1 → two valid pulses, 0x3C then 0xC3, no overrun.
- `rxd` low for 3 oversample ticks then high, 16× → no START→DATA, no `rx_valid`, `busy` returns 0 at tick C+1.
- Send 0x55 with stop bit 0 → `rx_data`=0x55, `rx_valid`=1, `framing_err`=1.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11, `overrun_err`=1 after second frame.
- Assert `reset` low during bit 4 of 0xF0, release, send 0x0F → only 0x0F delivered, all outputs 0 during reset.
